// File: rtl/fsk_pkg.sv
// Shared FSK baseband definitions: default sample format, symbol rate,
// demodulator state encoding and accumulator sizing.
package fsk_pkg;

  localparam int FSK_DATA_W = 13;
  localparam int FSK_SPS    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } demod_state_e;

  // One symbol's worth of full-precision discriminator outputs cannot overflow this.
  function automatic int fsk_acc_w(input int data_w, input int sps);
    return 2 * data_w + 1 + $clog2(sps);
  endfunction

endpackage

// File: rtl/fsk_discriminator.sv
// Quadrature frequency discriminator: disc = I[n-1]*Q[n] - Q[n-1]*I[n],
// registered at full precision together with the sample's symbol-align flag.
module fsk_discriminator
  import fsk_pkg::*;
#(
  parameter  int DATA_W = FSK_DATA_W,
  localparam int DISC_W = 2 * DATA_W + 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     valid_i,
  input  logic                     compute_i,
  input  logic signed [DATA_W-1:0] i_i,
  input  logic signed [DATA_W-1:0] q_i,
  input  logic                     align_i,
  output logic signed [DISC_W-1:0] disc_o,
  output logic                     disc_valid_o,
  output logic                     align_o
);

  logic signed [DATA_W-1:0] prev_i_q, prev_q_q;
  logic signed [DISC_W-1:0] disc_q, disc_d;
  logic                     disc_valid_q, align_q;
  logic signed [DISC_W-1:0] pi_x, pq_x, ci_x, cq_x;

  assign pi_x = {{(DISC_W-DATA_W){prev_i_q[DATA_W-1]}}, prev_i_q};
  assign pq_x = {{(DISC_W-DATA_W){prev_q_q[DATA_W-1]}}, prev_q_q};
  assign ci_x = {{(DISC_W-DATA_W){i_i[DATA_W-1]}}, i_i};
  assign cq_x = {{(DISC_W-DATA_W){q_i[DATA_W-1]}}, q_i};

  assign disc_d = (pi_x * cq_x) - (pq_x * ci_x);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      prev_i_q     <= '0;
      prev_q_q     <= '0;
      disc_q       <= '0;
      disc_valid_q <= 1'b0;
      align_q      <= 1'b0;
    end else begin
      disc_valid_q <= 1'b0;
      if (valid_i) begin
        prev_i_q <= i_i;
        prev_q_q <= q_i;
        if (compute_i) begin
          disc_q       <= disc_d;
          disc_valid_q <= 1'b1;
          align_q      <= align_i;
        end
      end
    end
  end

  assign disc_o       = disc_q;
  assign disc_valid_o = disc_valid_q;
  assign align_o      = align_q;

endmodule

// File: rtl/fsk_demodulator.sv
// FSK demodulator: discriminator, per-symbol integrate-and-dump and hard slicer.
// Build option FSK_DEMOD_DISC_OUT_EN exposes the registered discriminator as discOut/discValid.
module fsk_demodulator
  import fsk_pkg::*;
#(
  parameter int          DATA_W  = FSK_DATA_W,
  parameter int          SPS     = FSK_SPS,
  parameter int          ACC_W   = fsk_acc_w(DATA_W, SPS),
  parameter int unsigned MIN_MAG = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sampleValid,
  input  logic signed [DATA_W-1:0] FSK_I,
  input  logic signed [DATA_W-1:0] FSK_Q,
  input  logic                     symAlign,
  output logic                     symVal,
  output logic                     symValid,
  output logic                     symErr,
  output logic                     locked
`ifdef FSK_DEMOD_DISC_OUT_EN
  ,
  output logic signed [2*DATA_W:0] discOut,
  output logic                     discValid
`endif
);

  localparam int DISC_W = 2 * DATA_W + 1;
  localparam int CNT_W  = $clog2(SPS);
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(SPS - 1);
  localparam logic [ACC_W-1:0] ACC_MOST_NEG = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [ACC_W-1:0] ACC_MAX_POS  = {1'b0, {(ACC_W-1){1'b1}}};

  demod_state_e state_q, state_d;
  logic         compute_en;

  logic signed [DISC_W-1:0] disc;
  logic                     disc_valid, disc_align;
  logic [ACC_W-1:0]         disc_ext;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d, first_disc;
  logic [ACC_W-1:0] acc_mag;
  logic             below_min;
  logic             sym_val_q, sym_valid_q, sym_err_q, locked_q;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (sampleValid) begin
      case (state_q)
        IDLE:    state_d = PRIME;
        PRIME:   state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  // The very first sample only seeds the previous-sample register.
  always_comb begin
    compute_en = (state_q != IDLE);
  end

  fsk_discriminator #(.DATA_W(DATA_W)) u_disc (
    .clk_i        (clk),
    .rst_ni       (rst),
    .valid_i      (sampleValid),
    .compute_i    (compute_en),
    .i_i          (FSK_I),
    .q_i          (FSK_Q),
    .align_i      (symAlign),
    .disc_o       (disc),
    .disc_valid_o (disc_valid),
    .align_o      (disc_align)
  );

  assign disc_ext = {{(ACC_W-DISC_W){disc[DISC_W-1]}}, disc};

  always_comb begin
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    last_d     = 1'b0;
    first_disc = disc_align || (cnt_q == '0);
    if (disc_valid) begin
      acc_d  = first_disc ? disc_ext : (acc_q + disc_ext);
      if (first_disc)             cnt_d = CNT_W'(1);
      else if (cnt_q == CNT_LAST) cnt_d = '0;
      else                        cnt_d = cnt_q + 1'b1;
      last_d = !disc_align && (cnt_q == CNT_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      last_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end

  always_comb begin
    if (acc_q == ACC_MOST_NEG)  acc_mag = ACC_MAX_POS;
    else if (acc_q[ACC_W-1])    acc_mag = -acc_q;
    else                        acc_mag = acc_q;
  end

  // mag < MIN_MAG written as mag+1 <= MIN_MAG so MIN_MAG=0 folds cleanly to never.
  assign below_min = (({1'b0, acc_mag} + 1'b1) <= (ACC_W+1)'(MIN_MAG));

  always_ff @(posedge clk) begin
    if (!rst) begin
      sym_val_q   <= 1'b0;
      sym_valid_q <= 1'b0;
      sym_err_q   <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      sym_valid_q <= last_q;
      if (last_q) begin
        sym_val_q <= !acc_q[ACC_W-1] && (acc_q != '0);
        sym_err_q <= below_min;
        locked_q  <= 1'b1;
      end
    end
  end

  assign symVal   = sym_val_q;
  assign symValid = sym_valid_q;
  assign symErr   = sym_err_q;
  assign locked   = locked_q;

`ifdef FSK_DEMOD_DISC_OUT_EN
  assign discOut   = disc;
  assign discValid = disc_valid;
`endif

endmodule

// File: tb/tb_fsk_demodulator.sv
// Self-checking bench for fsk_demodulator: directed vector table, hand-built
// corner sequences and randomized traffic against a sample-level reference model.
module tb_fsk_demodulator;

  localparam int DATA_W  = 13;
  localparam int SPS     = 4;
  localparam int MIN_MAG = 1000;

  logic clk = 1'b0;
  logic rst, sampleValid, symAlign;
  logic signed [DATA_W-1:0] FSK_I, FSK_Q;
  logic symVal, symValid, symErr, locked;
`ifdef FSK_DEMOD_DISC_OUT_EN
  logic signed [2*DATA_W:0] discOut;
  logic discValid;
`endif

  fsk_demodulator #(.DATA_W(DATA_W), .SPS(SPS), .MIN_MAG(MIN_MAG)) dut (
    .clk         (clk),
    .rst         (rst),
    .sampleValid (sampleValid),
    .FSK_I       (FSK_I),
    .FSK_Q       (FSK_Q),
    .symAlign    (symAlign),
    .symVal      (symVal),
    .symValid    (symValid),
    .symErr      (symErr),
    .locked      (locked)
`ifdef FSK_DEMOD_DISC_OUT_EN
    ,
    .discOut     (discOut),
    .discValid   (discValid)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model state: sample-level arithmetic, expected strobes due at edge k+2.
  typedef struct { int due; bit val; bit err; } exp_t;
  exp_t   m_q[$];
  bit     m_have_prev = 0;
  longint m_pi = 0, m_pq = 0, m_sum = 0;
  int     m_cnt = 0;
  bit     m_locked = 0;

  int strobe_q[$];
  bit rx_q[$];

  int rot_i[4] = '{4000, 0, -4000, 0};
  int rot_q[4] = '{0, 4000, 0, -4000};

  typedef struct {
    bit v; int i; int q; bit al; bit rn;
    bit e_valid; bit e_val; bit e_err; bit e_locked;
  } vec_t;
  vec_t tbl[16];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_edge(input bit v, input int i, input int q, input bit al, input bit rn);
    longint d, a;
    exp_t e;
    if (!rn) begin
      m_have_prev = 0; m_cnt = 0; m_sum = 0; m_locked = 0;
      m_q.delete();
    end else if (v) begin
      if (!m_have_prev) begin
        m_have_prev = 1;
      end else begin
        d = m_pi * longint'(q) - m_pq * longint'(i);
        if (al || m_cnt == 0) begin m_sum = d; m_cnt = 1; end
        else begin m_sum += d; m_cnt++; end
        if (m_cnt == SPS) begin
          a = (m_sum < 0) ? -m_sum : m_sum;
          e.due = cyc + 2; e.val = (m_sum > 0); e.err = (a < MIN_MAG);
          m_q.push_back(e);
          m_cnt = 0;
        end
      end
      m_pi = i; m_pq = q;
    end
  endtask

  task automatic model_check();
    bit ev;
    ev = 0;
    if (m_q.size() > 0) ev = (m_q[0].due == cyc);
    chk("symValid", symValid, ev);
    if (ev) begin
      chk("symVal", symVal, m_q[0].val);
      chk("symErr", symErr, m_q[0].err);
      m_locked = 1;
      void'(m_q.pop_front());
    end
    chk("locked", locked, m_locked);
  endtask

  task automatic step(input bit v, input int i, input int q, input bit al, input bit rn);
    sampleValid = v;
    FSK_I = i[DATA_W-1:0];
    FSK_Q = q[DATA_W-1:0];
    symAlign = al;
    rst = rn;
    @(posedge clk);
    cyc++;
    model_edge(v, i, q, al, rn);
    @(negedge clk);
    if (symValid === 1'b1) begin
      strobe_q.push_back(cyc);
      rx_q.push_back(symVal);
    end
    model_check();
  endtask

  function automatic int rnd_s();
    return int'($urandom_range(0, 8191)) - 4096;
  endfunction

  initial begin
    int n, p, align_cyc, idx;
    bit pat[4];
    pat[0] = 0; pat[1] = 0; pat[2] = 1; pat[3] = 1;

    for (int r = 0; r < 16; r++) begin
      idx = r % 4;
      tbl[r].v = 1; tbl[r].i = rot_i[idx]; tbl[r].q = rot_q[idx];
      tbl[r].al = (idx == 0); tbl[r].rn = 1;
      tbl[r].e_valid  = (r == 9) || (r == 13);
      tbl[r].e_val    = tbl[r].e_valid;
      tbl[r].e_err    = 0;
      tbl[r].e_locked = (r >= 9);
    end

    // Reset held with random valid traffic: everything stays cleared.
    for (int k = 0; k < 10; k++) begin
      step($urandom_range(0, 1), rnd_s(), rnd_s(), $urandom_range(0, 1), 0);
      chk("rst_symValid", symValid, 0);
      chk("rst_symVal", symVal, 0);
      chk("rst_symErr", symErr, 0);
      chk("rst_locked", locked, 0);
    end

    // Positive quarter rotation from the vector table.
    for (int r = 0; r < 16; r++) begin
      step(tbl[r].v, tbl[r].i, tbl[r].q, tbl[r].al, tbl[r].rn);
      chk("tbl_symValid", symValid, tbl[r].e_valid);
      if (tbl[r].e_valid) begin
        chk("tbl_symVal", symVal, tbl[r].e_val);
        chk("tbl_symErr", symErr, tbl[r].e_err);
      end
      chk("tbl_locked", locked, tbl[r].e_locked);
    end

    // Negative quarter rotation.
    step(0, 0, 0, 0, 0);
    for (int k = 0; k < 16; k++) begin
      idx = (4 - (k % 4)) % 4;
      step(1, rot_i[idx], rot_q[idx], (k % 4) == 0, 1);
    end

    // Constant sample: zero sum, erasure.
    step(0, 0, 0, 0, 0);
    for (int k = 0; k < 16; k++) step(1, 3000, 0, (k % 4) == 0, 1);

    // Loopback: continuous-phase quarter-rotation FSK, pattern 0,0,1,1.
    step(0, 0, 0, 0, 0);
    rx_q.delete();
    p = 0;
    for (int m = 0; m < 28; m++) begin
      for (int s = 0; s < SPS; s++) begin
        p = pat[m % 4] ? (p + 1) % 4 : (p + 3) % 4;
        step(1, rot_i[p], rot_q[p], s == 0, 1);
      end
    end
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("loop_count", rx_q.size(), 27);
    for (int j = 0; j < 27 && j < rx_q.size(); j++) chk("loop_sym", rx_q[j], pat[(j + 1) % 4]);

    // Valid every other clock: strobes every 8 clocks.
    step(0, 0, 0, 0, 0);
    strobe_q.delete();
    for (int k = 0; k < 68; k++) begin
      n = k / 2;
      if (k % 2 == 0) step(1, rot_i[n % 4], rot_q[n % 4], (n % 4) == 0, 1);
      else            step(0, rnd_s(), rnd_s(), $urandom_range(0, 1), 1);
    end
    chk("gap_strobes", strobe_q.size(), 7);
    for (int j = 1; j < strobe_q.size(); j++) chk("gap_spacing", strobe_q[j] - strobe_q[j-1], 8);

    // Realign mid-symbol at cnt=2.
    step(0, 0, 0, 0, 0);
    align_cyc = 0;
    for (int k = 0; k < 16; k++) begin
      step(1, rot_i[k % 4], rot_q[k % 4], (k == 0) || (k == 4) || (k == 6) || (k == 10) || (k == 14), 1);
      if (k == 6) begin align_cyc = cyc; strobe_q.delete(); end
    end
    chk("realign_strobe_seen", strobe_q.size() > 0, 1);
    if (strobe_q.size() > 0) chk("realign_delay", strobe_q[0] - align_cyc, SPS - 1 + 2);

    // Mid-operation reset at cnt=3.
    step(0, 0, 0, 0, 0);
    for (int k = 0; k < 11; k++) step(1, rot_i[k % 4], rot_q[k % 4], (k % 4) == 0, 1);
    chk("pre_rst_locked", locked, 1);
    step(1, rot_i[3], rot_q[3], 0, 0);
    chk("mid_rst_symValid", symValid, 0);
    chk("mid_rst_symVal", symVal, 0);
    chk("mid_rst_locked", locked, 0);
    for (int k = 0; k < 12; k++) step(1, rot_i[k % 4], rot_q[k % 4], (k % 4) == 0, 1);

    // Randomized traffic with occasional realigns and resets.
    for (int k = 0; k < 600; k++) begin
      step($urandom_range(0, 9) < 7, rnd_s(), rnd_s(), $urandom_range(0, 19) == 0,
           $urandom_range(0, 99) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
